// File: rtl/apu_timer_bank.sv
// rtl/apu_timer_bank.sv - bank of independent programmable down-count timers
// Each channel reloads from its period slice on trigger and strobes pulse on expiry.
module apu_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] period,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;

        // Priority: disable, then trigger, then expiry/decrement on a tick.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            if (!enable[i]) begin
                state_d = IDLE;
            end else if (trigger[i]) begin
                cnt_d   = period[i*WIDTH +: WIDTH];
                state_d = RUN;
            end else if (state_q == RUN && tick) begin
                if (cnt_q == '0) begin
                    pulse_d = 1'b1;
                    if (mode[i]) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = period[i*WIDTH +: WIDTH];
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse[i]   = pulse_q;
        assign running[i] = (state_q == RUN);
    end

endmodule
